// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider; new divisor/enable settings take effect only at a div_clk falling edge.
// Optional define CLK_DIV_CTRL_TICK_CNT_EN adds a free-running 16-bit tick counter output (tick_cnt).
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | divider stopped, div_clk low, commands update div_q directly
// ST_RUN   | divider running on div_q, ready for a new command
// ST_DRAIN | divider running on old div_q, pending command waits for fall
module clk_div_ctrl #(
  parameter int          CNT_W   = 32,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic             err
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_div;
  logic             pend_en;
  logic             accept;
  logic             legal;
  logic             tc;

  assign accept = cfg_valid && cfg_ready;
  assign legal  = (cfg_div != '0);
  // div_q is never 0, so div_q-1 cannot wrap and counter stays below div_q.
  assign tc     = (state != ST_IDLE) && (counter == div_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept && legal && cfg_en) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && legal) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tc && div_clk) begin
          next_state = pend_en ? ST_RUN : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    cfg_ready = (state != ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      div_q    <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      pend_en  <= 1'b0;
      div_clk  <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err  <= accept && !legal;
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          counter <= '0;
          div_clk <= 1'b0;
          if (accept && legal) begin
            div_q <= cfg_div;
          end
        end
        ST_RUN: begin
          if (tc) begin
            div_clk <= ~div_clk;
            tick    <= 1'b1;
            counter <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
          if (accept && legal) begin
            pend_div <= cfg_div;
            pend_en  <= cfg_en;
          end
        end
        ST_DRAIN: begin
          if (tc) begin
            div_clk <= ~div_clk;
            tick    <= 1'b1;
            counter <= '0;
            // Only a falling toggle closes the period; that is when the new divisor is safe.
            if (div_clk && pend_en) begin
              div_q <= pend_div;
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          counter <= '0;
          div_clk <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= 16'h0000;
    end else if (tc) begin
      tick_cnt <= tick_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start-up, reconfiguration through DRAIN, illegal command,
// stop, reset mid-DRAIN, and tick_cnt wrap when CLK_DIV_CTRL_TICK_CNT_EN is defined.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic        cfg_en;
  logic        div_clk;
  logic        tick;
  logic        busy;
  logic        err;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_ctrl #(.CNT_W(32), .DEF_DIV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .div_clk   (div_clk),
    .tick      (tick),
    .busy      (busy),
    .err       (err)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    ,
    .tick_cnt  (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clk and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] div, input logic en);
    cfg_valid = 1'b1;
    cfg_div   = div;
    cfg_en    = en;
    step();
    cfg_valid = 1'b0;
  endtask

  // Count cycles until div_clk changes; tick must be low until then and high on the toggle.
  task automatic wait_edge(input string tag, input int exp_n);
    logic prev;
    int   n;
    bit   seen;
    prev = div_clk;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      step();
      n++;
      if (div_clk !== prev) seen = 1'b1;
      else chk({tag, "_tick_lo"}, tick, 1'b0);
    end
    chk({tag, "_cycles"}, n, exp_n);
    chk({tag, "_tick_hi"}, tick, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_div_clk"}, div_clk, 1'b0);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, cfg_ready, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = 32'd0;
    cfg_en    = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();

    // Start at div=3: rise 3 cycles after entering RUN, then every 3 cycles.
    send(32'd3, 1'b1);
    chk("run_busy", busy, 1'b1);
    chk("run_div_clk0", div_clk, 1'b0);
    wait_edge("t1_rise", 3);
    chk("t1_high", div_clk, 1'b1);
    wait_edge("t1_fall", 3);
    chk("t1_low", div_clk, 1'b0);

    // Illegal command one cycle after the fall: err pulses once, period unchanged.
    send(32'd0, 1'b1);
    chk("ill_err", err, 1'b1);
    chk("ill_busy", busy, 1'b1);
    chk("ill_ready", cfg_ready, 1'b1);
    step();
    chk("ill_err_clr", err, 1'b0);
    wait_edge("t3_rise", 1);
    wait_edge("t3_fall", 3);

    // Reconfigure to 5 while div_clk is low: old period completes, then period 10.
    send(32'd5, 1'b1);
    chk("drain_ready", cfg_ready, 1'b0);
    chk("drain_busy", busy, 1'b1);
    wait_edge("t2_rise_old", 2);
    chk("drain_ready2", cfg_ready, 1'b0);
    wait_edge("t2_fall_old", 3);
    chk("t2_ready_back", cfg_ready, 1'b1);
    wait_edge("t2_rise_new", 5);
    wait_edge("t2_fall_new", 5);

    // Stop: finishes after the next falling edge, then IDLE with div_clk held low.
    send(32'd5, 1'b0);
    chk("stop_ready", cfg_ready, 1'b0);
    wait_edge("t4_rise", 4);
    wait_edge("t4_fall", 5);
    chk("stop_busy", busy, 1'b0);
    chk("stop_ready_idle", cfg_ready, 1'b1);
    for (int i = 0; i < 8; i++) step();
    chk("idle_div_clk", div_clk, 1'b0);
    chk("idle_tick", tick, 1'b0);

    // Reset in the middle of DRAIN drops the pending command.
    send(32'd2, 1'b1);
    wait_edge("t5_rise", 2);
    send(32'd4, 1'b1);
    chk("t5_drain_ready", cfg_ready, 1'b0);
    rst = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_after_busy", busy, 1'b0);
    chk("t5_after_div_clk", div_clk, 1'b0);

    // Same-cycle command and terminal count: toggle still uses the old divisor.
    send(32'd2, 1'b1);
    step();
    send(32'd6, 1'b1);
    chk("tc_cmd_rise", div_clk, 1'b1);
    chk("tc_cmd_tick", tick, 1'b1);
    wait_edge("tc_cmd_fall", 2);
    wait_edge("tc_cmd_new_rise", 6);

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    rst = 1'b1;
    step();
    chk("cnt_rst", tick_cnt, 16'h0000);
    rst = 1'b0;
    send(32'd1, 1'b1);
    chk("cnt_start", tick_cnt, 16'h0000);
    for (int i = 0; i < 65537; i++) step();
    chk("cnt_wrap", tick_cnt, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
